// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite data memory: response codes and FSM states.
package axi_lite_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi_lite_sram_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), free-running, loads seed on reset.
// Kept standalone so other delay-injecting components can reuse it.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Right-shifting Galois step; feedback mask 0xB8 encodes taps 8,6,5,4
    always_comb begin
        q_d = {1'b0, q_q[7:1]};
        if (q_q[0]) begin
            q_d = q_d ^ 8'hB8;
        end
    end

    // State register, advances every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave word memory with independent read/write FSMs and a
// per-transaction pseudo-random response latency.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [7:0]  LAT_MASK   = 8'h1f,
    parameter bit          RANDOM_LAT = 1'b1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

    logic [7:0] lfsr_val;
    logic [7:0] lat;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_val)
    );

    // Both FSMs sample the same value, so simultaneous draws agree
    assign lat = RANDOM_LAT ? (lfsr_val & LAT_MASK) : LAT_MASK;

    // Read path state
    rd_state_t   rd_state_q, rd_state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rd_load;

    // Write path state
    wr_state_t   wr_state_q, wr_state_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_commit;

    // Address decode: offset from base wraps modulo 2^32, low two bits ignored
    logic [31:0]           rd_off, wr_off;
    logic                  rd_in_range, wr_in_range;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic                  aw_hs, w_hs;
    logic                  unused_bits;

    assign rd_off      = rd_addr_q - BASE_ADDR;
    assign wr_off      = wr_addr_q - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_off} < SPAN;
    assign wr_in_range = {1'b0, wr_off} < SPAN;
    assign rd_idx      = rd_off[DEPTH_LOG2+1:2];
    assign wr_idx      = wr_off[DEPTH_LOG2+1:2];
    assign unused_bits = ^{wstrb[7:4], rd_off[1:0], wr_off[1:0]};

    assign aw_hs = awvalid & awready_q;
    assign w_hs  = wvalid & wready_q;

    // Read FSM next-state: accept address, count latency, present and hold response
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rd_addr_d  = araddr;
                    rd_cnt_d   = lat;
                    arready_d  = 1'b0;
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 8'd0) begin
                    rd_load    = 1'b1;
                    rresp_d    = rd_in_range ? AXI_OKAY : AXI_SLVERR;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 8'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM next-state: capture AW and W in any order, count latency, commit, respond
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_cnt_d   = wr_cnt_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wr_addr_d = awaddr;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    wr_data_d = wdata;
                    wr_strb_d = wstrb[3:0];
                    wready_d  = 1'b0;
                end
                // A dropped ready means that half was captured earlier
                if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                    wr_cnt_d   = lat;
                    wr_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == 8'd0) begin
                    // Reset in the commit cycle abandons the write
                    wr_commit  = wr_in_range & ~rst;
                    bresp_d    = wr_in_range ? AXI_OKAY : AXI_SLVERR;
                    bvalid_d   = 1'b1;
                    wr_state_d = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXI_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
        end
    end

    // Write FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_cnt_q   <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_cnt_q   <= wr_cnt_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // One RAM per byte lane; a read and commit to the same word in one cycle returns old data
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte_q;

        // Byte-lane write port
        always_ff @(posedge clk) begin
            if (wr_commit && wr_strb_q[gi]) begin
                mem[wr_idx] <= wr_data_q[8*gi +: 8];
            end
        end

        // Registered read port, zero for out-of-range loads
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_byte_q <= 8'h00;
            end else if (rd_load) begin
                rd_byte_q <= rd_in_range ? mem[rd_idx] : 8'h00;
            end
        end

        assign rdata[8*gi +: 8] = rd_byte_q;
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Scoreboard bench for axi_lite_sram: a fixed-latency instance for directed
// scenarios and a random-latency instance for a randomized run, selected by sel.
`timescale 1ns/1ps
module tb_axi_lite_sram;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [32:0] SPAN = 33'h1_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic        rready = 1'b1, bready = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  wstrb = '0;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic        f_arready, f_rvalid, f_awready, f_wready, f_bvalid;
    logic [31:0] f_rdata;
    logic [1:0]  f_rresp, f_bresp;
    logic        x_arready, x_rvalid, x_awready, x_wready, x_bvalid;
    logic [31:0] x_rdata;
    logic [1:0]  x_rresp, x_bresp;

    always #5 clk = ~clk;

    axi_lite_sram #(.RANDOM_LAT(1'b0), .LAT_MASK(8'h03)) dut_fix (
        .clk(clk), .rst(rst),
        .arvalid(arvalid & ~sel), .arready(f_arready), .araddr(araddr),
        .rvalid(f_rvalid), .rready(rready), .rdata(f_rdata), .rresp(f_rresp),
        .awvalid(awvalid & ~sel), .awready(f_awready), .awaddr(awaddr),
        .wvalid(wvalid & ~sel), .wready(f_wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(f_bvalid), .bready(bready), .bresp(f_bresp)
    );

    axi_lite_sram dut_rnd (
        .clk(clk), .rst(rst),
        .arvalid(arvalid & sel), .arready(x_arready), .araddr(araddr),
        .rvalid(x_rvalid), .rready(rready), .rdata(x_rdata), .rresp(x_rresp),
        .awvalid(awvalid & sel), .awready(x_awready), .awaddr(awaddr),
        .wvalid(wvalid & sel), .wready(x_wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(x_bvalid), .bready(bready), .bresp(x_bresp)
    );

    assign arready = sel ? x_arready : f_arready;
    assign rvalid  = sel ? x_rvalid  : f_rvalid;
    assign rdata   = sel ? x_rdata   : f_rdata;
    assign rresp   = sel ? x_rresp   : f_rresp;
    assign awready = sel ? x_awready : f_awready;
    assign wready  = sel ? x_wready  : f_wready;
    assign bvalid  = sel ? x_bvalid  : f_bvalid;
    assign bresp   = sel ? x_bresp   : f_bresp;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          t;
        int          lat;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];
    exp_t rcur, bcur;
    bit   r_act = 0, b_act = 0;
    int   r_issued = 0, r_done = 0, b_issued = 0, b_done = 0;
    int   cyc = 0;
    int   checks = 0, failures = 0;

    // Reference memory: word index -> value; only in-range words ever stored
    logic [31:0] mem_m [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    // Exact latency when known, else the 2..33 cycle window
    function automatic void lat_chk(string name, int got, int exp);
        checks++;
        if ((exp >= 0 && got != exp) || (exp < 0 && (got < 2 || got > 33))) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (negative means 2..33)", name, got, exp);
        end
    endfunction

    function automatic bit inr(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic int widx(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    // Response monitor: pops expectations when a response appears, checks hold while waiting
    always @(negedge clk) begin
        if (rst) begin
            r_act = 0;
            b_act = 0;
        end else begin
            if (rvalid) begin
                if (!r_act) begin
                    if (rq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL r_unexpected: got rvalid=1 required no pending read");
                    end else begin
                        rcur = rq.pop_front();
                        r_act = 1;
                        lat_chk("r_latency", cyc - rcur.t, rcur.lat);
                        $display("RD addr=%h data=%h resp=%0d lat=%0d", rcur.addr, rdata, rresp, cyc - rcur.t);
                    end
                end
                if (r_act) begin
                    chk("r_data", rdata, rcur.data);
                    chk("r_resp", {30'd0, rresp}, {30'd0, rcur.resp});
                    if (rready) begin
                        r_act = 0;
                        r_done++;
                    end
                end
            end
            if (bvalid) begin
                if (!b_act) begin
                    if (bq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_unexpected: got bvalid=1 required no pending write");
                    end else begin
                        bcur = bq.pop_front();
                        b_act = 1;
                        lat_chk("b_latency", cyc - bcur.t, bcur.lat);
                        $display("WR addr=%h data=%h resp=%0d lat=%0d", bcur.addr, bcur.data, bresp, cyc - bcur.t);
                    end
                end
                if (b_act) begin
                    chk("b_resp", {30'd0, bresp}, {30'd0, bcur.resp});
                    if (bready) begin
                        b_act = 0;
                        b_done++;
                    end
                end
            end
        end
    end

    // Write: lead>0 puts W that many cycles ahead of AW, lead<0 puts AW ahead
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int el);
        exp_t e;
        bit   aw_ok, w_ok;
        int   k, n, t, aw_start, w_start;
        logic [31:0] v;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_ok = 0; w_ok = 0; k = 0; t = 0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = {4'($urandom), s};
        while (!(aw_ok && w_ok) && k < 200) begin
            awvalid = !aw_ok && k >= aw_start;
            wvalid  = !w_ok && k >= w_start;
            @(negedge clk);
            if (w_ok && !aw_ok) begin
                chk("order_wready_low", {31'd0, wready}, 32'd0);
                chk("order_awready_high", {31'd0, awready}, 32'd1);
            end
            if (aw_ok && !w_ok) begin
                chk("order_awready_low", {31'd0, awready}, 32'd0);
                chk("order_wready_high", {31'd0, wready}, 32'd1);
            end
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            t = cyc;
            @(posedge clk); #1;
            k++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_ok && w_ok)) begin
            checks++; failures++;
            $display("FAIL w_handshake_timeout: got aw=%0d w=%0d required both accepted", aw_ok, w_ok);
            return;
        end
        e.addr = a; e.data = d; e.t = t; e.lat = el;
        e.resp = inr(a) ? 2'b00 : 2'b10;
        if (inr(a)) begin
            v = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            mem_m[widx(a)] = v;
        end
        bq.push_back(e);
        b_issued++;
        n = 0;
        while (b_done < b_issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b_done < b_issued) begin
            checks++; failures++;
            $display("FAIL b_timeout: got b_done=%0d required %0d", b_done, b_issued);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int el, input bit wait_done);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        arvalid = 1; araddr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 200);
        if (!arready) begin
            checks++; failures++;
            $display("FAIL ar_timeout: got arready=0 required 1");
            arvalid = 0;
            return;
        end
        e.addr = a; e.t = cyc; e.lat = el;
        e.resp = inr(a) ? 2'b00 : 2'b10;
        e.data = (inr(a) && mem_m.exists(widx(a))) ? mem_m[widx(a)] : 32'd0;
        rq.push_back(e);
        r_issued++;
        @(posedge clk); #1;
        arvalid = 0;
        if (wait_done) begin
            n = 0;
            while (r_done < r_issued && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (r_done < r_issued) begin
                checks++; failures++;
                $display("FAIL r_timeout: got r_done=%0d required %0d", r_done, r_issued);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int n, lead;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd1);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);

        // Fixed latency 3: response five cycles after the handshake
        do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 5);
        do_read(BASE + 32'h10, 5, 1);

        // Byte strobes
        do_write(BASE + 32'h20, 32'h11223344, 4'hF, 0, 5);
        do_write(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 5);
        do_read(BASE + 32'h20, 5, 1);

        // Channel ordering: W first by three cycles, then AW first by two
        do_write(BASE + 32'h30, 32'h0F1E2D3C, 4'hF, 3, 5);
        do_read(BASE + 32'h30, 5, 1);
        do_write(BASE + 32'h34, 32'hC0FFEE00, 4'hF, -2, 5);
        do_read(BASE + 32'h34, 5, 1);

        // Backpressure: hold rready low, a second AR must wait
        rready = 0;
        do_read(BASE + 32'h10, 5, 0);
        n = 0;
        while (!rvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1; araddr = BASE + 32'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
            chk("bp_arready", {31'd0, arready}, 32'd0);
        end
        @(posedge clk); #1;
        rready = 1;
        do_read(BASE + 32'h20, 5, 1);

        // Out of range
        do_write(BASE, 32'h0BADF00D, 4'hF, 0, 5);
        do_read(32'h7FFF_FFFC, 5, 1);
        do_write(BASE + 32'h0001_0000, 32'h12345678, 4'hF, 0, 5);
        do_read(BASE, 5, 1);

        // Reset while the write is counting down: no commit, interface idle
        @(posedge clk); #1;
        awaddr = BASE + 32'h10; wdata = 32'h5555AAAA; wstrb = 8'h0F;
        awvalid = 1; wvalid = 1;
        @(negedge clk);
        chk("rstw_handshake", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstw_arready", {31'd0, arready}, 32'd1);
        chk("rstw_awready", {31'd0, awready}, 32'd1);
        chk("rstw_wready", {31'd0, wready}, 32'd1);
        chk("rstw_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rstw_bvalid", {31'd0, bvalid}, 32'd0);
        do_read(BASE + 32'h10, 5, 1);

        // Randomized run on the random-latency instance
        sel = 1;
        mem_m.delete();
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13:
                    a = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
                14, 15, 16:
                    a = BASE + 32'h0000_FFFC - (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
                17: a = BASE - 32'd4;
                18: a = BASE + 32'h0001_0000;
                default: a = 32'($urandom_range(0, 3));
            endcase
            lead = int'($urandom_range(0, 6)) - 3;
            if (inr(a) && !mem_m.exists(widx(a))) begin
                do_write(a, $urandom, 4'hF, lead, -1);
            end else if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom), lead, -1);
            end else begin
                do_read(a, -1, 1);
            end
        end

        repeat (5) @(negedge clk);
        chk("rq_empty", rq.size(), 32'd0);
        chk("bq_empty", bq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram.md
Name: axi_lite_sram

Overview:
- AXI4-Lite slave data memory that sits directly downstream of the write-back/memory-access stage.
- Consumes its ar/r/aw/w/b channels and returns load data and store completion.
- Adds a programmable pseudo-random response latency so the requester's handshake and stall logic is exercised in simulation.
- Read and write paths are independent FSMs sharing one word-organised storage array.

Parameters:
- DEPTH_LOG2, 14, log2 of the number of 32-bit words (default 64 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LAT_MASK, 8'h1f, mask applied to the LFSR value to form the per-transaction extra latency.
- RANDOM_LAT, 1, 1 = LFSR latency; 0 = fixed latency of LAT_MASK cycles.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- arvalid in 1; arready out 1; araddr in 32
- rvalid out 1; rready in 1; rdata out 32; rresp out 2
- awvalid in 1; awready out 1; awaddr in 32
- wvalid in 1; wready out 1; wdata in 32; wstrb in 8 (bits [3:0] used, [7:4] ignored)
- bvalid out 1; bready in 1; bresp out 2

Behaviour:
- Reset values:
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - FSMs go to IDLE; LFSR loads LFSR_SEED.
  - Array contents are not reset.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2, modulo 2^32.
  - In range iff (addr - BASE_ADDR) < 4*2^DEPTH_LOG2.
  - addr[1:0] is ignored; accesses are word-aligned.
- Latency draw:
  - One value is taken at each accepted AR or completed AW+W pair: lat = RANDOM_LAT ? (lfsr & LAT_MASK) : LAT_MASK.
  - The LFSR is 8-bit Galois, taps x^8+x^6+x^5+x^4+1, and advances every cycle.
  - If a read and a write draw in the same cycle, both receive the same value.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid, latch araddr and lat, clear arready, go to R_WAIT.
  - R_WAIT: count down lat. When the count reaches 0, load rdata from the array (or 0 if out of range), set rresp = in range ? 2'b00 OKAY : 2'b10 SLVERR, set rvalid=1, go to R_RESP.
  - R_RESP: rdata and rresp stay stable while rvalid=1. On rready, clear rvalid, set arready=1, go to R_IDLE.
  - Minimum latency is AR handshake at cycle t to rvalid high at cycle t+2 (lat=0).
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle. Each ready drops after its own handshake.
  - When both have been captured, draw lat and go to W_WAIT.
  - W_WAIT: count down. At 0, commit the write for each wstrb[i]=1, byte i <= wdata[8i+7:8i]. Out-of-range writes are dropped.
  - Also at 0: set bresp (OKAY/SLVERR), bvalid=1, go to W_RESP.
  - W_RESP: on bready, clear bvalid, set awready=wready=1, go to W_IDLE.
- Read/write same word, same cycle: the read load and the write commit can coincide. The read then returns the old data (read-before-write).
- Reset mid-transaction: any pending read or write is abandoned. A write not yet committed does not modify the array.
- Simulation-only DPI/$display hooks are not part of this block.

Decomposition:
- Package axi_lite_pkg holds:
  - resp constants AXI_OKAY=2'b00, AXI_SLVERR=2'b10;
  - typedef enum rd_state_t {R_IDLE,R_WAIT,R_RESP};
  - typedef enum wr_state_t {W_IDLE,W_WAIT,W_RESP}.
- One sub-module, lfsr8, has ports clk, rst, seed, q[7:0]. It is reusable by other delay-injecting bench components.

Test Plan:
- Fixed latency (RANDOM_LAT=0, LAT_MASK=3):
  - Stimulus: write 0xDEADBEEF to 0x8000_0010, wstrb=4'hF, with AW and W in the same cycle.
  - Expected: bvalid exactly 5 cycles after the handshake, bresp=0.
  - Then read the same address. Expected: rdata=0xDEADBEEF, rresp=0.
- Byte strobes:
  - Stimulus: memory word 0x11223344, then write wdata=0xAABBCCDD with wstrb=4'b0101.
  - Expected: read returns 0x11BB33DD.
- Channel ordering:
  - Stimulus: assert W 3 cycles before AW.
  - Expected: wready drops after the W handshake and awready stays 1. The commit happens only after AW, with a single bvalid.
- Backpressure:
  - Stimulus: hold rready=0 for 10 cycles after rvalid.
  - Expected: rvalid, rdata and rresp stable throughout; arready stays 0; a new arvalid is not accepted until after the rready handshake.
- Out of range:
  - Stimulus: read at 0x7FFF_FFFC, and write to BASE+2^(DEPTH_LOG2+2).
  - Expected: rresp=2'b10, rdata=0, bresp=2'b10, array unchanged.
- Random latency and reset:
  - Stimulus: 1000 random read/write transactions checked against a scoreboard. Expected: all data matches and every latency is at most 33 cycles.
  - Stimulus: assert rst during W_WAIT. Expected: no commit, all readies=1 and valids=0 on the next cycle.
